// File: rtl/regfile_param.sv
// Parameterised register file: one byte-enabled write port, two registered read
// ports, per-entry written flags and a post-reset sequential clear of every entry.
module regfile_param #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned ZERO_REG = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       wr,
  input  logic [$clog2(DEPTH)-1:0]   wr_sel,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic [WIDTH/8-1:0]         wr_be,
  input  logic                       rd,
  input  logic [$clog2(DEPTH)-1:0]   rd_sel1,
  input  logic [$clog2(DEPTH)-1:0]   rd_sel2,
  output logic [WIDTH-1:0]           rd_data1,
  output logic [WIDTH-1:0]           rd_data2,
  output logic                       rd_valid,
  output logic                       rd_uninit1,
  output logic                       rd_uninit2,
  output logic                       busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned NB = WIDTH / 8;

  typedef enum logic {CLEAR, READY} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     clr_cnt_q, clr_cnt_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [DEPTH-1:0]  wflag_q;

  logic [WIDTH-1:0]  rd_data1_q, rd_data1_d, rd_data2_q, rd_data2_d;
  logic              rd_uninit1_q, rd_uninit1_d, rd_uninit2_q, rd_uninit2_d;
  logic              rd_valid_q, rd_valid_d;

  logic              wr_hit;
  logic              mem_we, mem_flag;
  logic [AW-1:0]     mem_idx;
  logic [WIDTH-1:0]  mem_wdata, merged;
  logic [WIDTH:0]    lookup1, lookup2;

  function automatic logic is_zero_entry(input logic [AW-1:0] idx);
    return (ZERO_REG != 0) && (idx == '0);
  endfunction

  // Returns {uninit, data}; a same-cycle write to the selected entry is forwarded.
  function automatic logic [WIDTH:0] rd_lookup(
    input logic [AW-1:0]    sel,
    input logic [WIDTH-1:0] entry,
    input logic             flag,
    input logic             hit,
    input logic [AW-1:0]    wsel,
    input logic [WIDTH-1:0] wval
  );
    if (is_zero_entry(sel))       return '0;
    else if (hit && wsel == sel)  return {1'b0, wval};
    else                          return {~flag, entry};
  endfunction

  always_comb begin
    merged = mem_q[wr_sel];
    for (int unsigned b = 0; b < NB; b++) begin
      if (wr_be[b]) merged[8*b +: 8] = wr_data[8*b +: 8];
    end
  end

  assign wr_hit  = en && wr && (|wr_be) && !is_zero_entry(wr_sel);
  assign lookup1 = rd_lookup(rd_sel1, mem_q[rd_sel1], wflag_q[rd_sel1], wr_hit, wr_sel, merged);
  assign lookup2 = rd_lookup(rd_sel2, mem_q[rd_sel2], wflag_q[rd_sel2], wr_hit, wr_sel, merged);

  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    mem_we       = 1'b0;
    mem_idx      = wr_sel;
    mem_wdata    = merged;
    mem_flag     = 1'b1;
    rd_valid_d   = 1'b0;
    rd_data1_d   = rd_data1_q;
    rd_data2_d   = rd_data2_q;
    rd_uninit1_d = rd_uninit1_q;
    rd_uninit2_d = rd_uninit2_q;
    if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_idx   = clr_cnt_q;
      mem_wdata = '0;
      mem_flag  = 1'b0;
      clr_cnt_d = clr_cnt_q + AW'(1);
      if (clr_cnt_q == '1) state_d = READY;
    end else begin
      mem_we = wr_hit;
      if (en && rd) begin
        rd_valid_d   = 1'b1;
        rd_data1_d   = lookup1[WIDTH-1:0];
        rd_uninit1_d = lookup1[WIDTH];
        rd_data2_d   = lookup2[WIDTH-1:0];
        rd_uninit2_d = lookup2[WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= CLEAR;
      clr_cnt_q    <= '0;
      rd_valid_q   <= 1'b0;
      rd_data1_q   <= '0;
      rd_data2_q   <= '0;
      rd_uninit1_q <= 1'b0;
      rd_uninit2_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      rd_valid_q   <= rd_valid_d;
      rd_data1_q   <= rd_data1_d;
      rd_data2_q   <= rd_data2_d;
      rd_uninit1_q <= rd_uninit1_d;
      rd_uninit2_q <= rd_uninit2_d;
    end
  end

  // Storage is not reset directly; the CLEAR sequence zeroes it after rst falls.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem_q[mem_idx]   <= mem_wdata;
      wflag_q[mem_idx] <= mem_flag;
    end
  end

  assign rd_data1   = rd_data1_q;
  assign rd_data2   = rd_data2_q;
  assign rd_valid   = rd_valid_q;
  assign rd_uninit1 = rd_uninit1_q;
  assign rd_uninit2 = rd_uninit2_q;
  assign busy       = (state_q == CLEAR);

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 Parameter WIDTH, default 32, data width in bits; SHALL be a multiple of 8, at least 8.
REQ-002 Parameter DEPTH, default 16, number of entries; SHALL be a power of two, at least 2; AW = log2(DEPTH).
REQ-003 Parameter ZERO_REG, default 0; 1 = entry 0 is hardwired to zero.
REQ-004 Ports SHALL be:
clk  in  1  single clock, all state updates on rising edge
rst  in  1  reset; synchronous and active-high
en  in  1  block enable; 0 = no read, no write
wr  in  1  write request
wr_sel  in  AW  write entry index
wr_data  in  WIDTH  write data
wr_be  in  WIDTH/8  byte enables for the write; bit i covers wr_data[8i+7:8i]
rd  in  1  read request (both ports)
rd_sel1  in  AW  read port 1 entry index
rd_sel2  in  AW  read port 2 entry index
rd_data1  out  WIDTH  read port 1 data, registered
rd_data2  out  WIDTH  read port 2 data, registered
rd_valid  out  1  one-cycle pulse: rd_data1/2 updated
rd_uninit1  out  1  port 1 entry not written since reset
rd_uninit2  out  1  port 2 entry not written since reset
busy  out  1  clear sequence in progress; requests ignored

Function
REQ-005 FSM states SHALL be CLEAR and READY, plus an AW-bit clear counter clr_cnt.
REQ-006 In CLEAR, each cycle SHALL zero entry clr_cnt, clear its written flag, and increment clr_cnt.
REQ-007 CLEAR SHALL move to READY on the cycle after entry DEPTH-1 is cleared, so busy=1 for exactly DEPTH cycles after rst falls.
REQ-008 In CLEAR, wr and rd SHALL be ignored: no array update, rd_valid=0, rd_data held.
REQ-009 In READY with en=1 and wr=1: bytes of entry wr_sel with wr_be=1 SHALL take wr_data; bytes with wr_be=0 SHALL be kept.
REQ-010 A write with any wr_be bit set SHALL set the entry's written flag; wr_be=0 SHALL change nothing.
REQ-011 In READY with en=1 and rd=1: rd_data1/2 SHALL show entries rd_sel1/rd_sel2 one cycle later, with rd_valid=1 in that cycle only.
REQ-012 Read-during-write to the same index SHALL be write-first: read data is the merged byte result of REQ-009; uninit flag=0 if any wr_be bit set.
REQ-013 Both read ports MAY select the same index and SHALL return identical data.
REQ-014 If ZERO_REG=1: writes to entry 0 SHALL be discarded; entry 0 SHALL read 0 with uninit=0.
REQ-015 rd_uninitN SHALL be registered with rd_dataN and SHALL hold with it when no read occurs.
REQ-016 en=0 SHALL suppress reads and writes; rd_valid=0; rd_data and uninit flags held.
REQ-017 Concurrent wr and rd with different indices SHALL both complete in the same cycle.

Reset
REQ-018 rst=1 at a clock edge SHALL force: state=CLEAR, clr_cnt=0, busy=1, rd_valid=0, rd_data1/2=0, rd_uninit1/2=0.
REQ-019 Held rst SHALL keep clr_cnt at 0; the DEPTH-cycle sequence SHALL start on the first edge with rst=0.
REQ-020 rst during CLEAR or READY SHALL abort the current operation and restart the sequence from entry 0.
REQ-021 A read issued in the cycle rst rises SHALL be discarded; no rd_valid pulse SHALL follow.

Verification
REQ-022 rst=1 5 cycles, then 0 -> busy=1 for exactly 16 cycles, then 0; read of every entry -> data 0, rd_uninit=1.
REQ-023 Write 0xABCDEFAB to entry 0 and 0x01234567 to entry 1 (wr_be=0xF); read sel1=0, sel2=1 -> next cycle rd_data1=0xABCDEFAB, rd_data2=0x01234567, rd_valid=1, uninit=0.
REQ-024 Entry 2=0x11223344; write 0xAABBCCDD with wr_be=4'b0101 -> read returns 0x11BB33DD.
REQ-025 Write 0xDEADBEEF to entry 5 with rd=1, rd_sel1=5 in the same cycle -> next cycle rd_data1=0xDEADBEEF, rd_uninit1=0.
REQ-026 ZERO_REG=1: write 0xFFFFFFFF to entry 0, then read -> 0x00000000, rd_uninit1=0.
REQ-027 Pulse rst when clr_cnt=7; issue writes while busy=1 -> busy lasts 16 more cycles after rst falls; dropped writes absent, entries read 0.
